// File: rtl/risc_pkg.sv
// Shared definitions for the risc boot loader: memory geometry and the
// loader state encoding, visible to the core top and the bench alike.
package risc_pkg;

   localparam int AWIDTH = 5;
   localparam int DWIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERR
   } LoaderState;

endpackage

// File: rtl/counter.sv
// Generic loadable up-counter, used by the loader as its write-address
// counter. Load takes priority over enable.
module counter #(
   parameter int WIDTH = 6
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadValue,
   input  logic             i_enab,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // Count register: cleared by reset, preset by load, else steps when enabled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_enab) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/risc_loader.sv
// Boot loader for the risc core. Receives a LEN / data / CSUM framed byte
// stream, writes the data bytes to consecutive memory addresses from 0, and
// releases the core from reset only once the whole frame has arrived with a
// matching modulo-2**DWIDTH checksum.
module risc_loader import risc_pkg::*; #(
   parameter int AWIDTH = risc_pkg::AWIDTH,
   parameter int DWIDTH = risc_pkg::DWIDTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_data,
   output logic              mem_wr,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Largest legal frame length is the full memory size. Lengths are held one
   // bit wider than the address so that a full-memory frame can be counted.
   localparam logic [DWIDTH:0] MAX_LEN = (DWIDTH+1)'(2**AWIDTH);

   LoaderState        r_state;
   logic [AWIDTH:0]   r_len;
   logic [DWIDTH-1:0] r_sum;
   logic              r_cpuRst;
   logic              r_memWr;
   logic [AWIDTH-1:0] r_memAddr;
   logic [DWIDTH-1:0] r_memData;

   logic              w_inReady;
   logic              w_accept;
   logic              w_countLoad;
   logic              w_countEnab;
   logic [AWIDTH:0]   w_count;
   logic [AWIDTH:0]   w_countNext;
   logic              w_lenBad;

   // Receive-state decode and the byte handshake
   assign w_inReady   = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
   assign w_accept    = in_valid && w_inReady;
   assign w_countLoad = (r_state == LEN) && w_accept;
   assign w_countEnab = (r_state == DATA) && w_accept;
   assign w_countNext = w_count + {{AWIDTH{1'b0}}, 1'b1};
   assign w_lenBad    = (in_data == '0) || ({1'b0, in_data} > MAX_LEN);

   counter #(
      .WIDTH       (AWIDTH + 1)
   ) u_addrCounter (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_countLoad),
      .i_loadValue ('0),
      .i_enab      (w_countEnab),
      .o_count     (w_count)
   );

   // Frame parser: state, length, running checksum, write strobe and core reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_sum     <= '0;
         r_cpuRst  <= 1'b1;
         r_memWr   <= 1'b0;
         r_memAddr <= '0;
         r_memData <= '0;
      end else begin
         r_memWr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) r_state <= LEN;
            end
            LEN: begin
               if (w_accept) begin
                  if (w_lenBad) begin
                     r_state <= ERR;
                  end else begin
                     r_len   <= (AWIDTH+1)'(in_data);
                     r_sum   <= '0;
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_accept) begin
                  r_memAddr <= w_count[AWIDTH-1:0];
                  r_memData <= in_data;
                  r_memWr   <= 1'b1;
                  r_sum     <= r_sum + in_data;
                  if (w_countNext == r_len) r_state <= CSUM;
               end
            end
            CSUM: begin
               if (w_accept) begin
                  if (in_data == r_sum) begin
                     r_state  <= DONE;
                     r_cpuRst <= 1'b0;
                  end else begin
                     r_state <= ERR;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  r_state  <= LEN;
                  r_cpuRst <= 1'b1;
               end
            end
            ERR: begin
               if (start) r_state <= LEN;
            end
            default: begin
               r_state  <= IDLE;
               r_cpuRst <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready = w_inReady;
   assign mem_addr = r_memAddr;
   assign mem_data = r_memData;
   assign mem_wr   = r_memWr;
   assign cpu_rst  = r_cpuRst;
   assign busy     = w_inReady;
   assign done     = (r_state == DONE);
   assign err      = (r_state == ERR);

endmodule

// File: tb/tb_risc_loader.sv
// Self-checking bench for risc_loader. Frames are checked against a simple
// behavioural model: a frame is good when 1 <= LEN <= 32 and CSUM equals the
// byte sum modulo 256; every data byte of a legal-length frame is written in
// order to addresses 0, 1, 2, ...
module tb_risc_loader;

   localparam int MEMSZ = 32;

   typedef logic [7:0] ByteQ[$];
   typedef struct {
      int addr;
      int data;
      int cyc;
   } WrRec;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_wr;
   logic       cpu_rst;
   logic       busy;
   logic       done;
   logic       err;

   int         checks = 0;
   int         errors = 0;
   int         cycle = 0;
   WrRec       wrLog[$];
   logic [7:0] memSeen[MEMSZ];
   logic [7:0] expMem[MEMSZ];

   risc_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wr   (mem_wr),
      .cpu_rst  (cpu_rst),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to confirm back-to-back writes
   always @(posedge clk) cycle++;

   // Memory-side monitor: logs every write strobe and keeps an image of memory
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         WrRec r;
         r.addr = int'(mem_addr);
         r.data = int'(mem_data);
         r.cyc  = cycle;
         wrLog.push_back(r);
         memSeen[mem_addr] = mem_data;
      end
   end

   // Hard time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pulse start for one cycle and confirm the loader is now receiving LEN
   task automatic startPulse(input string name);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s start: got busy=%b in_ready=%b cpu_rst=%b done=%b want 1 1 1 0",
                  name, busy, in_ready, cpu_rst, done);
      end
   endtask

   // Stream bytes one at a time; with stall set, in_valid is low every other cycle
   task automatic sendBytes(input ByteQ bytes, input bit stall, input int startIdx,
                            input string name, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < bytes.size(); i++) begin
         int tries;
         bit acc;
         bit phase;
         tries = 0;
         acc   = 1'b0;
         phase = 1'b0;
         while (!acc) begin
            @(negedge clk);
            in_data  = bytes[i];
            in_valid = stall ? phase : 1'b1;
            phase    = ~phase;
            start    = (i == startIdx);
            #1;
            if (!in_valid) begin
               checks++;
               if (in_ready !== 1'b1) begin
                  errors++;
                  $display("[TB] FAIL %s ready_in_gap byte %0d: got %b want 1", name, i, in_ready);
               end
            end
            acc = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            tries++;
            if (!acc && tries > 20) begin
               checks++;
               errors++;
               $display("[TB] FAIL %s accept_timeout byte %0d: got no accept in %0d cycles, want accept",
                        name, i, tries);
               ok = 1'b0;
               return;
            end
         end
      end
   endtask

   // Start a load, stream a frame and check outcome and memory writes against the model
   task automatic runFrame(input ByteQ frame, input bit stall, input int startIdx, input string name);
      int   n;
      int   sum;
      bit   lenOk;
      bit   good;
      bit   ok;
      int   nWr;
      ByteQ toSend;
      wrLog.delete();
      startPulse(name);
      n     = int'(frame[0]);
      lenOk = (n >= 1) && (n <= MEMSZ);
      good  = 1'b0;
      if (lenOk) begin
         sum = 0;
         for (int k = 1; k <= n; k++) sum += int'(frame[k]);
         good   = (int'(frame[n+1]) == (sum % 256));
         toSend = frame;
      end else begin
         toSend = frame[0:0];
      end
      sendBytes(toSend, stall, startIdx, name, ok);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      checks++;
      if (done !== good) begin
         errors++;
         $display("[TB] FAIL %s done: got %b want %b", name, done, good);
      end
      checks++;
      if (err !== !good) begin
         errors++;
         $display("[TB] FAIL %s err: got %b want %b", name, err, !good);
      end
      checks++;
      if (cpu_rst !== !good) begin
         errors++;
         $display("[TB] FAIL %s cpu_rst: got %b want %b", name, cpu_rst, !good);
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s idle_handshake: got busy=%b in_ready=%b want 0 0", name, busy, in_ready);
      end
      nWr = lenOk ? n : 0;
      checks++;
      if (wrLog.size() !== nWr) begin
         errors++;
         $display("[TB] FAIL %s write_count: got %0d want %0d", name, wrLog.size(), nWr);
      end
      for (int k = 0; k < nWr; k++) expMem[k] = frame[k+1];
      for (int k = 0; k < nWr && k < wrLog.size(); k++) begin
         checks++;
         if (wrLog[k].addr !== k || wrLog[k].data !== int'(frame[k+1])) begin
            errors++;
            $display("[TB] FAIL %s write %0d: got addr=%0d data=%02h want addr=%0d data=%02h",
                     name, k, wrLog[k].addr, wrLog[k].data, k, frame[k+1]);
         end
         if (!stall && k > 0) begin
            checks++;
            if (wrLog[k].cyc !== wrLog[k-1].cyc + 1) begin
               errors++;
               $display("[TB] FAIL %s write_spacing %0d: got cycle %0d want %0d",
                        name, k, wrLog[k].cyc, wrLog[k-1].cyc + 1);
            end
         end
      end
   endtask

   // Build a random frame; LEN may be illegal and the checksum may be wrong
   task automatic makeFrame(output ByteQ frame);
      int n;
      int sum;
      frame.delete();
      if ($urandom_range(0, 7) == 0) begin
         n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
         frame.push_back(8'(n));
         return;
      end
      n   = int'($urandom_range(1, MEMSZ));
      sum = 0;
      frame.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         frame.push_back(b);
         sum += int'(b);
      end
      if ($urandom_range(0, 3) == 0) sum += int'($urandom_range(1, 255));
      frame.push_back(8'(sum % 256));
   endtask

   // Reset values of every output
   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_rst !== 1'b1 || mem_wr !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset ctrl: got cpu_rst=%b mem_wr=%b in_ready=%b want 1 0 0", cpu_rst, mem_wr, in_ready);
      end
      checks++;
      if (mem_addr !== 5'd0 || mem_data !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset mem: got addr=%0d data=%02h want 0 00", mem_addr, mem_data);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset status: got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
      end
      in_valid = 1'b1;
      in_data  = 8'h03;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem_wr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_ignores_valid: got busy=%b mem_wr=%b want 0 0", busy, mem_wr);
      end
   endtask

   task automatic test_nominal();
      ByteQ f;
      f = '{8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hE3};
      runFrame(f, 1'b0, -1, "nominal");
   endtask

   task automatic test_bad_checksum();
      ByteQ f;
      f = '{8'h02, 8'h10, 8'h20, 8'h31};
      runFrame(f, 1'b0, -1, "bad_checksum");
   endtask

   task automatic test_len_bounds();
      ByteQ f;
      int   sum;
      f = '{8'h00};
      runFrame(f, 1'b0, -1, "len_zero");
      f = '{8'h21};
      runFrame(f, 1'b0, -1, "len_33");
      f.delete();
      f.push_back(8'h20);
      sum = 0;
      for (int k = 0; k < MEMSZ; k++) begin
         f.push_back(8'(k * 7 + 3));
         sum += (k * 7 + 3) % 256;
      end
      f.push_back(8'(sum % 256));
      runFrame(f, 1'b0, -1, "len_32");
   endtask

   task automatic test_stalls();
      ByteQ f;
      f = '{8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hE3};
      runFrame(f, 1'b1, -1, "stalls");
   endtask

   // Reload from DONE, then a start pulse in the middle of DATA
   task automatic test_restart();
      ByteQ f;
      f = '{8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hE3};
      runFrame(f, 1'b0, -1, "restart_first");
      f = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      runFrame(f, 1'b0, 2, "restart_mid_data");
   endtask

   // Reset after two of three data bytes, then a fresh load
   task automatic test_reset_midload();
      ByteQ f;
      bit   ok;
      wrLog.delete();
      startPulse("reset_midload");
      f = '{8'h03, 8'h11, 8'h22};
      sendBytes(f, 1'b0, -1, "reset_midload", ok);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 5'd1 || mem_data !== 8'h22) begin
         errors++;
         $display("[TB] FAIL reset_midload pending_write: got wr=%b addr=%0d data=%02h want 1 1 22",
                  mem_wr, mem_addr, mem_data);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_rst !== 1'b1 || mem_wr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_midload after_rst: got busy=%b done=%b err=%b cpu_rst=%b mem_wr=%b want 0 0 0 1 0",
                  busy, done, err, cpu_rst, mem_wr);
      end
      rst = 1'b0;
      expMem[0] = 8'h11;
      expMem[1] = 8'h22;
      checks++;
      if (memSeen[0] !== 8'h11 || memSeen[1] !== 8'h22) begin
         errors++;
         $display("[TB] FAIL reset_midload kept_bytes: got %02h %02h want 11 22", memSeen[0], memSeen[1]);
      end
      f = '{8'h03, 8'h05, 8'h06, 8'h07, 8'h12};
      runFrame(f, 1'b0, -1, "after_reset_load");
   endtask

   // Random frames with random stalls, then a full memory image comparison
   task automatic test_random();
      ByteQ f;
      for (int t = 0; t < 10; t++) begin
         makeFrame(f);
         runFrame(f, 1'($urandom_range(0, 1)), -1, $sformatf("random%0d", t));
      end
      for (int a = 0; a < MEMSZ; a++) begin
         checks++;
         if (memSeen[a] !== expMem[a]) begin
            errors++;
            $display("[TB] FAIL memory_image addr %0d: got %02h want %02h", a, memSeen[a], expMem[a]);
         end
      end
   endtask

   // Test sequence
   initial begin
      for (int a = 0; a < MEMSZ; a++) begin
         memSeen[a] = 8'h00;
         expMem[a]  = 8'h00;
      end
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_len_bounds();
      test_stalls();
      test_restart();
      test_reset_midload();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc_loader.md
Name: risc_loader

Overview:
Boot loader that sits directly upstream of the risc core. It accepts a framed byte stream over a valid/ready handshake and writes the program image into the core's data/program memory. It holds the core in reset until a complete frame with a correct checksum has been written. Frame format: LEN byte, then LEN data bytes, then a CSUM byte.

Parameters:
AWIDTH, 5, memory address width; max image is 2**AWIDTH bytes.
DWIDTH, 8, memory/stream data width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load
in_data  input  DWIDTH  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
mem_addr  output  AWIDTH  memory write address
mem_data  output  DWIDTH  memory write data
mem_wr  output  1  one-cycle memory write strobe
cpu_rst  output  1  reset to the risc core; high = held in reset
busy  output  1  load in progress
done  output  1  image loaded and verified; core running
err  output  1  frame rejected

Behaviour:
- Reset: state=IDLE, cpu_rst=1, mem_wr=0, mem_addr=0, mem_data=0, in_ready=0, busy=0, done=0, err=0, count=0, sum=0.
- Handshake: a byte is accepted on a rising edge where in_valid&&in_ready. in_ready=1 only in LEN, DATA and CSUM; it is a combinational decode of state.
- Arithmetic: sum is DWIDTH bits and wraps modulo 2**DWIDTH. Address wraps naturally at 2**AWIDTH, but a legal LEN never reaches the wrap.
- States:
  - IDLE: start -> LEN.
  - LEN: on accept, if in_data==0 or in_data>2**AWIDTH -> ERR; else len<=in_data, count<=0, sum<=0 -> DATA.
  - DATA: on accept, register mem_addr<=count, mem_data<=in_data, pulse mem_wr for exactly the next cycle; sum<=sum+in_data; count<=count+1. When count+1==len -> CSUM.
  - CSUM: on accept, if in_data==sum -> DONE, else -> ERR.
  - DONE: cpu_rst=0. start -> LEN, and cpu_rst returns to 1 on the same edge.
  - ERR: cpu_rst stays 1. start -> LEN.
- Write latency: mem_wr is high in the cycle after each DATA accept, with mem_addr/mem_data stable for that cycle. Writes are to consecutive addresses starting at 0.
- cpu_rst is registered. It is cleared on the CSUM->DONE edge, so it is low from the first DONE cycle. It is set on any exit from DONE and on rst.
- busy=1 in LEN, DATA and CSUM. done=(state==DONE). err=(state==ERR).
- start is ignored in LEN, DATA and CSUM; the load in progress continues unaffected.
- in_valid with in_ready=0 is ignored; no byte is consumed.
- Back-to-back accepts, one per cycle, are supported in every receiving state.
- rst mid-load: the next cycle is IDLE, with any pending mem_wr dropped and cpu_rst=1. Bytes already written to memory stay there.
- The core's halt has no effect on the loader.

Decomposition:
- Shared package risc_pkg holds AWIDTH, DWIDTH and the loader state enum (IDLE, LEN, DATA, CSUM, DONE, ERR) for use by the core top and the bench.
- The write-address count reuses the existing counter module (load=start-of-frame with 0, enab=DATA accept). No other sub-module.

Test Plan:
- Nominal load: rst, start, stream 03,A0,A1,A2,E3 with in_valid held high -> mem_wr pulses write addr0=A0, addr1=A1, addr2=A2 on consecutive cycles; done=1 and cpu_rst=0 the cycle after E3 is accepted.
- Bad checksum: start, stream 02,10,20,31 -> err=1, cpu_rst stays 1, done=0; both data bytes were still written.
- Length bounds: LEN=00 -> ERR with no mem_wr. LEN=21 (33) -> ERR. LEN=20 (32) with 32 bytes and the correct sum -> writes addr 0..31, DONE.
- Stalls: toggle in_valid every other cycle during the nominal frame -> identical writes and result; in_ready stays 1 through the gaps.
- Reload and restart: in DONE, pulse start -> cpu_rst=1 next cycle and state=LEN. A start pulse mid-DATA is ignored.
- Reset mid-load: assert rst after 2 of 3 data bytes -> next cycle IDLE, cpu_rst=1, mem_wr=0; a fresh full frame then loads correctly.
